// File: rtl/bitcoin_pkg.sv
// Shared types and constants for the bitcoin hasher back end.
// State encoding, result-record offsets and status-word layout.
package bitcoin_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RD_H0,
    RD_H1,
    CAPT,
    WR0,
    WR1,
    WR2,
    WR3,
    DONE
  } state_e;

  localparam logic [15:0] RES_STATUS = 16'd0;
  localparam logic [15:0] RES_NONCE  = 16'd1;
  localparam logic [15:0] RES_HI     = 16'd2;
  localparam logic [15:0] RES_LO     = 16'd3;

  localparam int FOUND_BIT = 31;

endpackage

// File: rtl/hash_target_checker_if.sv
// Single-port word memory bus shared with the hasher.
// master: mem_clk/we/addr/write_data out, read_data in.
interface hash_target_checker_if;

  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport master (
    output mem_clk,
    output mem_we,
    output mem_addr,
    output mem_write_data,
    input  mem_read_data
  );

  modport slave (
    input  mem_clk,
    input  mem_we,
    input  mem_addr,
    input  mem_write_data,
    output mem_read_data
  );

endinterface

// File: rtl/hash_min_tracker.sv
// Running min / below-target counter over a stream of 64-bit hashes.
// Ports: clk, reset, clear, valid, hash, target, nonce -> best_*, count, found_any.
module hash_min_tracker (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        valid,
  input  logic [63:0] hash,
  input  logic [63:0] target,
  input  logic [15:0] nonce,
  output logic [63:0] best_hash,
  output logic [31:0] best_nonce,
  output logic [15:0] count,
  output logic        found_any
);

  logic [63:0] best_hash_q, best_hash_d;
  logic [31:0] best_nonce_q, best_nonce_d;
  logic [15:0] count_q, count_d;
  logic        found_q, found_d;

  always_comb begin
    best_hash_d  = best_hash_q;
    best_nonce_d = best_nonce_q;
    count_d      = count_q;
    found_d      = found_q;
    if (clear) begin
      best_hash_d  = '1;
      best_nonce_d = '0;
      count_d      = '0;
      found_d      = 1'b0;
    end else if (valid) begin
      if (hash < target) begin
        found_d = 1'b1;
        if (count_q != 16'hFFFF)
          count_d = count_q + 16'd1;
      end
      // strict compare: an equal later hash keeps the earlier nonce
      if (hash < best_hash_q) begin
        best_hash_d  = hash;
        best_nonce_d = {16'b0, nonce};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_hash_q  <= '1;
      best_nonce_q <= '0;
      count_q      <= '0;
      found_q      <= 1'b0;
    end else begin
      best_hash_q  <= best_hash_d;
      best_nonce_q <= best_nonce_d;
      count_q      <= count_d;
      found_q      <= found_d;
    end
  end

  assign best_hash  = best_hash_q;
  assign best_nonce = best_nonce_q;
  assign count      = count_q;
  assign found_any  = found_q;

endmodule

// File: rtl/hash_target_checker.sv
// Scans NUM_NONCES hashes in memory against a target, writes a 4-word record.
// Ports: clk, reset, start, hash_addr, result_addr, target -> done, found, best_nonce; mem bus.
module hash_target_checker
  import bitcoin_pkg::*;
#(
  parameter int unsigned NUM_NONCES  = 16,
  parameter int unsigned HASH_STRIDE = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] hash_addr,
  input  logic [15:0] result_addr,
  input  logic [63:0] target,
  output logic        done,
  output logic        found,
  output logic [31:0] best_nonce,
  hash_target_checker_if.master mem
);

  localparam logic [15:0] LAST   = 16'(NUM_NONCES - 1);
  localparam logic [15:0] STRIDE = 16'(HASH_STRIDE);

  state_e      state_q, state_d;
  logic [15:0] i_q, i_d;
  logic [15:0] hbase_q, hbase_d;
  logic [15:0] rbase_q, rbase_d;
  logic [63:0] target_q, target_d;
  logic [31:0] h0_q, h0_d;
  logic        found_q, found_d;
  logic [31:0] bnonce_q, bnonce_d;

  logic        trk_clear;
  logic        trk_valid;
  logic [63:0] trk_best_hash;
  logic [31:0] trk_best_nonce;
  logic [15:0] trk_count;
  logic        trk_found;

  logic        we_c;
  logic [15:0] addr_c;
  logic [31:0] wdata_c;
  logic        done_c;
  logic [15:0] rd_addr;

  // 16-bit wrap is intended
  assign rd_addr = hbase_q + i_q * STRIDE;

  hash_min_tracker u_trk (
    .clk        (clk),
    .reset      (reset),
    .clear      (trk_clear),
    .valid      (trk_valid),
    .hash       ({h0_q, mem.mem_read_data}),
    .target     (target_q),
    .nonce      (i_q),
    .best_hash  (trk_best_hash),
    .best_nonce (trk_best_nonce),
    .count      (trk_count),
    .found_any  (trk_found)
  );

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    hbase_d   = hbase_q;
    rbase_d   = rbase_q;
    target_d  = target_q;
    h0_d      = h0_q;
    found_d   = found_q;
    bnonce_d  = bnonce_q;
    trk_clear = 1'b0;
    trk_valid = 1'b0;
    we_c      = 1'b0;
    addr_c    = '0;
    wdata_c   = '0;
    done_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          hbase_d   = hash_addr;
          rbase_d   = result_addr;
          target_d  = target;
          i_d       = '0;
          trk_clear = 1'b1;
          state_d   = RD_H0;
        end
      end
      RD_H0: begin
        addr_c  = rd_addr;
        state_d = RD_H1;
      end
      RD_H1: begin
        // read data here answers the RD_H0 address
        addr_c  = rd_addr + 16'd1;
        h0_d    = mem.mem_read_data;
        state_d = CAPT;
      end
      CAPT: begin
        trk_valid = 1'b1;
        if (i_q == LAST) begin
          state_d = WR0;
        end else begin
          i_d     = i_q + 16'd1;
          state_d = RD_H0;
        end
      end
      WR0: begin
        we_c    = 1'b1;
        addr_c  = rbase_q + RES_STATUS;
        wdata_c = {16'b0, trk_count};
        wdata_c[FOUND_BIT] = trk_found;
        state_d = WR1;
      end
      WR1: begin
        we_c    = 1'b1;
        addr_c  = rbase_q + RES_NONCE;
        wdata_c = trk_best_nonce;
        state_d = WR2;
      end
      WR2: begin
        we_c    = 1'b1;
        addr_c  = rbase_q + RES_HI;
        wdata_c = trk_best_hash[63:32];
        state_d = WR3;
      end
      WR3: begin
        we_c     = 1'b1;
        addr_c   = rbase_q + RES_LO;
        wdata_c  = trk_best_hash[31:0];
        found_d  = trk_found;
        bnonce_d = trk_best_nonce;
        state_d  = DONE;
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      i_q      <= '0;
      hbase_q  <= '0;
      rbase_q  <= '0;
      target_q <= '0;
      h0_q     <= '0;
      found_q  <= 1'b0;
      bnonce_q <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      hbase_q  <= hbase_d;
      rbase_q  <= rbase_d;
      target_q <= target_d;
      h0_q     <= h0_d;
      found_q  <= found_d;
      bnonce_q <= bnonce_d;
    end
  end

  // bus outputs decode straight from state so reset clears them at once
  assign mem.mem_clk        = clk;
  assign mem.mem_we         = we_c;
  assign mem.mem_addr       = addr_c;
  assign mem.mem_write_data = wdata_c;

  assign done       = done_c;
  assign found      = found_q;
  assign best_nonce = bnonce_q;

endmodule

// File: tb/tb_hash_target_checker.sv
// Bench for hash_target_checker: directed table, corner sequences, random vs model.
// Two instances: NUM_NONCES=16 (a) and NUM_NONCES=1 (b).
module tb_hash_target_checker;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic [15:0] ha_a, ra_a, ha_b, ra_b;
  logic [63:0] tg_a, tg_b;
  logic        done_a, found_a, done_b, found_b;
  logic [31:0] bn_a, bn_b;

  always #5 clk = ~clk;

  hash_target_checker_if bus_a ();
  hash_target_checker_if bus_b ();

  hash_target_checker #(.NUM_NONCES(16), .HASH_STRIDE(8)) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .hash_addr(ha_a), .result_addr(ra_a), .target(tg_a),
    .done(done_a), .found(found_a), .best_nonce(bn_a),
    .mem(bus_a.master)
  );

  hash_target_checker #(.NUM_NONCES(1), .HASH_STRIDE(8)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .hash_addr(ha_b), .result_addr(ra_b), .target(tg_b),
    .done(done_b), .found(found_b), .best_nonce(bn_b),
    .mem(bus_b.master)
  );

  logic [31:0] mem_a [0:65535];
  logic [31:0] mem_b [0:65535];
  logic [31:0] rd_a, rd_b;
  logic        ld_en;
  logic [15:0] ld_addr;
  logic [31:0] ld_data;
  int wr_a = 0, dn_a = 0;

  always @(posedge clk) begin
    if (ld_en) begin
      mem_a[ld_addr] <= ld_data;
      mem_b[ld_addr] <= ld_data;
    end else begin
      if (bus_a.mem_we) mem_a[bus_a.mem_addr] <= bus_a.mem_write_data;
      if (bus_b.mem_we) mem_b[bus_b.mem_addr] <= bus_b.mem_write_data;
    end
    rd_a <= mem_a[bus_a.mem_addr];
    rd_b <= mem_b[bus_b.mem_addr];
  end

  assign bus_a.mem_read_data = rd_a;
  assign bus_b.mem_read_data = rd_b;

  always @(posedge clk) begin
    if (bus_a.mem_we) wr_a++;
    if (done_a) dn_a++;
  end

  int checks = 0;
  int errors = 0;
  logic [63:0] mh [0:N-1];

  typedef struct {
    int          pat;
    logic [63:0] tgt;
    logic [15:0] hb;
    logic [15:0] rb;
    logic [31:0] s;
    logic [31:0] n;
    logic [31:0] hi;
    logic [31:0] lo;
    int          gl;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic load_word(input logic [15:0] a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  task automatic load_hashes(input logic [15:0] hb);
    for (int i = 0; i < N; i++) begin
      load_word(hb + 16'(i * 8), mh[i][63:32]);
      load_word(hb + 16'(i * 8) + 16'd1, mh[i][31:0]);
    end
  endtask

  task automatic fill_pat(input int p);
    for (int i = 0; i < N; i++) begin
      case (p)
        0: mh[i] = {32'h1000_0000 + 32'(i), 32'h0};
        1: mh[i] = {32'h2000_0000 + 32'(i), 32'h55};
        2: mh[i] = '1;
        default: mh[i] = {32'h10, 32'(i)};
      endcase
    end
    if (p == 0) mh[5] = 64'h1;
    if (p == 1) begin
      mh[3] = '0;
      mh[9] = '0;
    end
  endtask

  // Reference: spec rules applied over the whole hash list at once.
  task automatic ref_model(input logic [63:0] tgt,
                           output logic [31:0] s, output logic [31:0] n,
                           output logic [31:0] hi, output logic [31:0] lo);
    int cnt = 0;
    int bi = 0;
    logic [63:0] best = '1;
    for (int i = 0; i < N; i++) begin
      if (mh[i] < tgt) cnt++;
      if (mh[i] < best) begin
        best = mh[i];
        bi   = i;
      end
    end
    s  = {cnt != 0, 15'b0, 16'(cnt)};
    n  = 32'(bi);
    hi = best[63:32];
    lo = best[31:0];
  endtask

  task automatic run_a(input string nm, input logic [15:0] hb,
                       input logic [15:0] rb, input logic [63:0] tgt,
                       input logic [31:0] s, input logic [31:0] n,
                       input logic [31:0] hi, input logic [31:0] lo,
                       input int gl);
    int cyc;
    int w0, d0;
    bit got;
    load_hashes(hb);
    @(negedge clk);
    w0 = wr_a;
    d0 = dn_a;
    start_a = 1'b1;
    ha_a = hb;
    ra_a = rb;
    tg_a = tgt;
    @(negedge clk);
    start_a = 1'b0;
    cyc = 1;
    got = 0;
    while (cyc < 200 && !got) begin
      if (done_a) begin
        got = 1;
      end else begin
        if (cyc == gl) start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cyc++;
      end
    end
    chk({nm, " done_cycle"}, 64'(cyc), 64'(3 * N + 5));
    chk({nm, " found"}, {63'b0, found_a}, {63'b0, s[31]});
    chk({nm, " best_nonce"}, {32'b0, bn_a}, {32'b0, n});
    if (gl == 3 * N + 5) start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat ((gl == 3 * N + 5) ? 60 : 4) @(negedge clk);
    chk({nm, " found_hold"}, {63'b0, found_a}, {63'b0, s[31]});
    chk({nm, " status"}, {32'b0, mem_a[rb]}, {32'b0, s});
    chk({nm, " nonce_w"}, {32'b0, mem_a[rb + 16'd1]}, {32'b0, n});
    chk({nm, " hash_hi"}, {32'b0, mem_a[rb + 16'd2]}, {32'b0, hi});
    chk({nm, " hash_lo"}, {32'b0, mem_a[rb + 16'd3]}, {32'b0, lo});
    chk({nm, " writes"}, 64'(wr_a - w0), 64'd4);
    chk({nm, " dones"}, 64'(dn_a - d0), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] es, en, eh, el;
    int cyc;
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    ha_a = '0; ra_a = '0; tg_a = '0;
    ha_b = '0; ra_b = '0; tg_b = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;

    tbl[0] = '{0, 64'h0000_0001_0000_0000, 16'h1000, 16'h2000,
               32'h8000_0001, 32'd5, 32'd0, 32'd1, 0};
    tbl[1] = '{1, '1, 16'h3000, 16'h3800,
               32'h8000_0010, 32'd3, 32'd0, 32'd0, 0};
    tbl[2] = '{2, '1, 16'h0400, 16'h0800,
               32'h0000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0};
    tbl[3] = '{3, {32'h10, 32'h8}, 16'hFFC0, 16'h4000,
               32'h8000_0008, 32'd0, 32'h10, 32'h0, 0};
    tbl[4] = '{0, 64'h0000_0001_0000_0000, 16'h5000, 16'h6000,
               32'h8000_0001, 32'd5, 32'd0, 32'd1, 2};
    tbl[5] = '{1, '1, 16'h7000, 16'h7100,
               32'h8000_0010, 32'd3, 32'd0, 32'd0, 3 * N + 5};

    repeat (3) @(negedge clk);
    chk("rst done", {63'b0, done_a}, 64'd0);
    chk("rst found", {63'b0, found_a}, 64'd0);
    chk("rst best_nonce", {32'b0, bn_a}, 64'd0);
    chk("rst mem_we", {63'b0, bus_a.mem_we}, 64'd0);
    chk("rst mem_addr", {48'b0, bus_a.mem_addr}, 64'd0);
    chk("rst mem_wdata", {32'b0, bus_a.mem_write_data}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      fill_pat(tbl[k].pat);
      run_a($sformatf("vec%0d", k), tbl[k].hb, tbl[k].rb, tbl[k].tgt,
            tbl[k].s, tbl[k].n, tbl[k].hi, tbl[k].lo, tbl[k].gl);
    end

    // reset asserted mid-record (WR1), then a clean rerun
    fill_pat(0);
    load_hashes(16'h0200);
    @(negedge clk);
    start_a = 1'b1;
    ha_a = 16'h0200;
    ra_a = 16'h0A00;
    tg_a = 64'h0000_0001_0000_0000;
    @(negedge clk);
    start_a = 1'b0;
    cyc = 1;
    while (cyc < 3 * N + 2) begin
      @(negedge clk);
      cyc++;
    end
    chk("wr1 mem_we", {63'b0, bus_a.mem_we}, 64'd1);
    chk("wr1 mem_addr", {48'b0, bus_a.mem_addr}, 64'h0A01);
    reset = 1'b1;
    #1;
    chk("arst mem_we", {63'b0, bus_a.mem_we}, 64'd0);
    chk("arst mem_addr", {48'b0, bus_a.mem_addr}, 64'd0);
    chk("arst mem_wdata", {32'b0, bus_a.mem_write_data}, 64'd0);
    chk("arst found", {63'b0, found_a}, 64'd0);
    chk("arst best_nonce", {32'b0, bn_a}, 64'd0);
    chk("arst done", {63'b0, done_a}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_a("after_rst", 16'h0200, 16'h0B00, 64'h0000_0001_0000_0000,
          32'h8000_0001, 32'd5, 32'd0, 32'd1, 0);

    // random hashes against the reference model
    for (int r = 0; r < 6; r++) begin
      logic [63:0] tgt;
      logic [15:0] hb;
      for (int i = 0; i < N; i++) mh[i] = {$urandom, $urandom};
      if (r == 2) mh[12] = mh[4];
      if (r == 0) tgt = '0;
      else if (r % 2 == 1) tgt = mh[$urandom_range(0, N - 1)];
      else tgt = {$urandom, $urandom};
      hb = 16'($urandom);
      ref_model(tgt, es, en, eh, el);
      run_a($sformatf("rand%0d", r), hb, hb ^ 16'h8000, tgt,
            es, en, eh, el, 0);
    end

    // single nonce with hash_addr at the top of memory: H1 wraps to 0
    load_word(16'hFFFF, 32'h0000_0002);
    load_word(16'h0000, 32'hDEAD_BEEF);
    @(negedge clk);
    start_b = 1'b1;
    ha_b = 16'hFFFF;
    ra_b = 16'h0100;
    tg_b = {32'h3, 32'h0};
    @(negedge clk);
    start_b = 1'b0;
    chk("b rd_h0 addr", {48'b0, bus_b.mem_addr}, 64'hFFFF);
    @(negedge clk);
    chk("b rd_h1 addr", {48'b0, bus_b.mem_addr}, 64'h0000);
    cyc = 2;
    while (cyc < 100 && !done_b) begin
      @(negedge clk);
      cyc++;
    end
    chk("b done_cycle", 64'(cyc), 64'd8);
    chk("b found", {63'b0, found_b}, 64'd1);
    chk("b best_nonce", {32'b0, bn_b}, 64'd0);
    @(negedge clk);
    chk("b status", {32'b0, mem_b[16'h0100]}, 64'h8000_0001);
    chk("b nonce_w", {32'b0, mem_b[16'h0101]}, 64'h0);
    chk("b hash_hi", {32'b0, mem_b[16'h0102]}, 64'h2);
    chk("b hash_lo", {32'b0, mem_b[16'h0103]}, 64'hDEAD_BEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
